// File: rtl/tanh_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tanh_arbiter
// Purpose  : Shares one pipelined tanh unit among NREQ requesters. Grants are
//            round-robin, each operand carries a requester tag through the
//            unit's LAT enabled stages, and results return on one tagged
//            stream with backpressure.
// Options  : TANH_ARB_FIXED_PRIO_EN -- lowest index always wins, no pointer.
// Revision : 1.0  initial release
// ============================================================================
module tanh_arbiter #(
   parameter int WIDTH = 32,
   parameter int NREQ  = 4,
   parameter int IDW   = 2,
   parameter int LAT   = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*WIDTH-1:0] req_data,
   output logic [NREQ-1:0]       req_ready,
   output logic [WIDTH-1:0]      tanh_a,
   output logic                  tanh_en,
   input  logic [WIDTH-1:0]      tanh_y,
   output logic [WIDTH-1:0]      y,
   output logic [IDW-1:0]        y_id,
   output logic                  y_valid,
   input  logic                  y_ready,
   output logic                  busy
);

   logic             tag_v  [LAT];
   logic [IDW-1:0]   tag_id [LAT];
   logic             advance;
   logic             found;
   logic             grant_en;
   logic [IDW-1:0]   grant;
   logic [WIDTH-1:0] next_a;
   logic [WIDTH-1:0] a_hold;
   int               arb_idx;

`ifndef TANH_ARB_FIXED_PRIO_EN
   logic [IDW-1:0]   ptr;
`endif

   // One global stall: everything moves only when the output stage can drain
   assign advance = !tag_v[LAT-1] || y_ready;
   assign tanh_en = advance;

   // Pick the first valid requester, starting at the pointer (or index 0)
   always_comb begin
      found   = 1'b0;
      grant   = '0;
      arb_idx = 0;
      for (int k = 0; k < NREQ; k++) begin
`ifdef TANH_ARB_FIXED_PRIO_EN
         arb_idx = k;
`else
         arb_idx = int'(ptr) + k;
         if (arb_idx >= NREQ) arb_idx = arb_idx - NREQ;
`endif
         if (!found && req_valid[arb_idx[IDW-1:0]]) begin
            found = 1'b1;
            grant = arb_idx[IDW-1:0];
         end
      end
   end

   // Grant is suppressed during reset so no transfer can be claimed then
   assign grant_en  = rst && found;
   assign req_ready = (grant_en && advance) ? (NREQ'(1) << grant) : '0;
   assign next_a    = grant_en ? req_data[int'(grant)*WIDTH +: WIDTH] : '0;
   assign tanh_a    = advance ? next_a : a_hold;

   // Remember the operand last presented on an enabled cycle for stalls
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)         a_hold <= '0;
      else if (advance) a_hold <= next_a;
   end

`ifndef TANH_ARB_FIXED_PRIO_EN
   // Pointer moves past the winner only on an actual transfer
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr <= '0;
      end else if (advance && grant_en) begin
         if (int'(grant) == NREQ - 1) ptr <= '0;
         else                         ptr <= grant + IDW'(1);
      end
   end
`endif

   // Entry stage: new tag on a transfer, bubble otherwise
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tag_v[0]  <= 1'b0;
         tag_id[0] <= '0;
      end else if (advance) begin
         tag_v[0]  <= grant_en;
         tag_id[0] <= grant_en ? grant : '0;
      end
   end

   generate
      for (genvar s = 1; s < LAT; s++) begin : g_stage
         // Tags shift in lockstep with the tanh unit's internal registers
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               tag_v[s]  <= 1'b0;
               tag_id[s] <= '0;
            end else if (advance) begin
               tag_v[s]  <= tag_v[s-1];
               tag_id[s] <= tag_id[s-1];
            end
         end
      end
   endgenerate

   // Anything still in flight keeps the block busy
   always_comb begin
      busy = 1'b0;
      for (int k = 0; k < LAT; k++) busy = busy | tag_v[k];
   end

   assign y       = tanh_y;
   assign y_id    = tag_id[LAT-1];
   assign y_valid = tag_v[LAT-1];

endmodule
`default_nettype wire

// File: tb/tb_tanh_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tanh_arbiter
// Purpose  : Directed self-checking bench for tanh_arbiter with a two-stage
//            enabled stand-in for the tanh unit.
// Revision : 1.0  initial release
// ============================================================================
module tb_tanh_arbiter;
   localparam int WIDTH = 32;
   localparam int NREQ  = 4;
   localparam int IDW   = 2;
   localparam int LAT   = 2;

   logic                  clk = 1'b0;
   logic                  rst = 1'b0;
   logic [NREQ-1:0]       req_valid = '0;
   logic [NREQ*WIDTH-1:0] req_data = '0;
   logic [NREQ-1:0]       req_ready;
   logic [WIDTH-1:0]      tanh_a;
   logic                  tanh_en;
   logic [WIDTH-1:0]      tanh_y;
   logic [WIDTH-1:0]      y;
   logic [IDW-1:0]        y_id;
   logic                  y_valid;
   logic                  y_ready = 1'b1;
   logic                  busy;

   int n_checks = 0;
   int n_fail   = 0;

   logic [WIDTH-1:0] s1, s2;
   logic [3:0]       exp_g;

   tanh_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW), .LAT(LAT)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .tanh_a(tanh_a), .tanh_en(tanh_en),
      .tanh_y(tanh_y), .y(y), .y_id(y_id), .y_valid(y_valid),
      .y_ready(y_ready), .busy(busy)
   );

   always #5 clk = ~clk;

   // Crude tanh stand-in: saturates beyond +/-4.0, passes small values through
   function automatic logic [WIDTH-1:0] tanh_model(input logic [WIDTH-1:0] a);
      if ($signed(a) >= $signed(32'h0400_0000))       return 32'h0100_0000;
      else if ($signed(a) <= $signed(32'hFC00_0000))  return 32'hFF00_0000;
      else                                            return a;
   endfunction

   // Operand register then output register, both gated by enable
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1 <= '0;
         s2 <= '0;
      end else if (tanh_en) begin
         s1 <= tanh_a;
         s2 <= tanh_model(s1);
      end
   end
   assign tanh_y = s2;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      #1 rst = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
   endtask

   initial begin
      // ---------------- reset state ----------------
      req_valid = 4'b0001;
      tick();
      chk("rst_req_ready", 32'(req_ready), 32'h0);
      chk("rst_tanh_en",   32'(tanh_en),   32'h1);
      chk("rst_tanh_a",    tanh_a,         32'h0);
      chk("rst_y_valid",   32'(y_valid),   32'h0);
      chk("rst_y_id",      32'(y_id),      32'h0);
      chk("rst_busy",      32'(busy),      32'h0);
      req_valid = '0;
      rst = 1'b1;
      tick();

      // ---------------- single operand, 4.5 -> 1.0 ----------------
      req_data[0*WIDTH +: WIDTH] = 32'h0480_0000;
      req_valid = 4'b0001;
      #1;
      chk("t1_req_ready", 32'(req_ready), 32'h1);
      chk("t1_tanh_a",    tanh_a,         32'h0480_0000);
      tick();
      req_valid = '0;
      #1;
      chk("t1_busy_mid",  32'(busy),    32'h1);
      chk("t1_y_valid0",  32'(y_valid), 32'h0);
      tick();
      chk("t1_y_valid",   32'(y_valid), 32'h1);
      chk("t1_y",         y,            32'h0100_0000);
      chk("t1_y_id",      32'(y_id),    32'h0);
      tick();
      chk("t1_y_valid_end", 32'(y_valid), 32'h0);
      chk("t1_busy_end",    32'(busy),    32'h0);

      // ---------------- all requesters valid ----------------
      do_reset();
      for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = 32'(i);
      req_valid = 4'b1111;
      for (int k = 0; k < 8; k++) begin
`ifdef TANH_ARB_FIXED_PRIO_EN
         exp_g = 4'd0;
`else
         exp_g = 4'(k % NREQ);
`endif
         #1;
         chk("t2_grant", 32'(req_ready), 32'h1 << exp_g);
         tick();
         if (k >= 1) begin
`ifdef TANH_ARB_FIXED_PRIO_EN
            exp_g = 4'd0;
`else
            exp_g = 4'((k - 1) % NREQ);
`endif
            chk("t2_y_valid", 32'(y_valid), 32'h1);
            chk("t2_y_id",    32'(y_id),    32'(exp_g));
            chk("t2_y",       y,            32'(exp_g));
         end
      end
      req_valid = '0;
      tick();
      chk("t2_last_valid", 32'(y_valid), 32'h1);
      tick();
      chk("t2_drained", 32'(busy), 32'h0);

      // ---------------- stall with -4.5 from requester 2 ----------------
      do_reset();
      y_ready = 1'b0;
      req_data[2*WIDTH +: WIDTH] = 32'hFB80_0000;
      req_valid = 4'b0100;
      #1;
      chk("t3_grant2", 32'(req_ready), 32'h4);
      tick();
      req_valid = '0;
      tick();
      req_data[0*WIDTH +: WIDTH] = 32'h0010_0000;
      req_valid = 4'b0001;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("t3_hold_valid", 32'(y_valid),   32'h1);
         chk("t3_hold_y",     y,              32'hFF00_0000);
         chk("t3_hold_id",    32'(y_id),      32'h2);
         chk("t3_hold_en",    32'(tanh_en),   32'h0);
         chk("t3_hold_ready", 32'(req_ready), 32'h0);
         chk("t3_hold_a",     tanh_a,         32'h0);
         tick();
      end
      y_ready = 1'b1;
      #1;
      chk("t3_release_ready", 32'(req_ready), 32'h1);
      chk("t3_release_a",     tanh_a,         32'h0010_0000);
      tick();
      req_valid = '0;
      chk("t3_retired", 32'(y_valid), 32'h0);
      chk("t3_busy",    32'(busy),    32'h1);
      tick();
      chk("t3_next_valid", 32'(y_valid), 32'h1);
      chk("t3_next_id",    32'(y_id),    32'h0);
      chk("t3_next_y",     y,            32'h0010_0000);
      tick();

      // ---------------- wrap from ptr=2 with requests on 1 and 3 ----------------
      do_reset();
      req_valid = 4'b0010;
      tick();
      req_valid = 4'b1010;
      #1;
`ifdef TANH_ARB_FIXED_PRIO_EN
      chk("t4_first", 32'(req_ready), 32'h2);
`else
      chk("t4_first", 32'(req_ready), 32'h8);
`endif
      tick();
      chk("t4_second", 32'(req_ready), 32'h2);
      req_valid = '0;
      tick();
      tick();
      tick();

      // ---------------- reset with two operands in flight ----------------
      req_valid = 4'b0011;
      tick();
      tick();
      req_valid = '0;
      chk("t5_busy_before", 32'(busy), 32'h1);
      #1 rst = 1'b0;
      #1;
      chk("t5_y_valid_rst", 32'(y_valid), 32'h0);
      chk("t5_busy_rst",    32'(busy),    32'h0);
      tick();
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("t5_no_stale", 32'(y_valid), 32'h0);
      end

      // ---------------- requesters 0 and 1 continuously valid ----------------
      do_reset();
      req_valid = 4'b0011;
      for (int k = 0; k < 4; k++) begin
         #1;
`ifdef TANH_ARB_FIXED_PRIO_EN
         chk("t6_grant", 32'(req_ready), 32'h1);
`else
         chk("t6_grant", 32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
`endif
         tick();
      end
      req_valid = '0;
      tick();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/tanh_arbiter.md
# tanh_arbiter

Round-robin arbiter and sequencer that shares one pipelined `tanh` activation unit among `NREQ` neuron requesters in the Q8.24 datapath. It accepts operands over per-requester valid/ready handshakes and drives the `tanh` unit's operand and enable. It tracks each in-flight operand with a requester tag through the unit's fixed latency, then returns results on a single tagged output stream with backpressure. It sits between the neuron array and a single `tanh` instance in the layer datapath.

## Interface
- `WIDTH`, 32, data word width (Q8.24 signed)
- `NREQ`, 4, number of requesters (2..16)
- `IDW`, 2, tag width; must satisfy 2^IDW >= NREQ
- `LAT`, 2, `tanh` latency in enabled cycles (operand register stage plus output register stage)

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `req_valid`  in  NREQ  requester i has an operand
- `req_data`  in  NREQ*WIDTH  operand of requester i, located at bits [i*WIDTH +: WIDTH]
- `req_ready`  out  NREQ  one-hot grant; a transfer occurs when valid and ready are both high
- `tanh_a`  out  WIDTH  operand to the `tanh` unit
- `tanh_en`  out  1  enable for the `tanh` unit
- `tanh_y`  in  WIDTH  result from the `tanh` unit
- `y`  out  WIDTH  result, equal to `tanh_y`
- `y_id`  out  IDW  requester index that owns `y`
- `y_valid`  out  1  result available
- `y_ready`  in  1  consumer accepts the result
- `busy`  out  1  at least one operand is in flight

## Operation
- Tag pipeline: `LAT` stages, each holding {valid, id}. Stage LAT-1 is the output stage.
- `advance` = !tag[LAT-1].valid || y_ready. It is a single global stall for the whole pipeline.
- `tanh_en` = advance. The tag pipe shifts only when advance is high, so tags stay aligned with `tanh` internal registers.
- Arbitration:
  - Round-robin pointer `ptr` (reset 0).
  - The granted requester is the first i with req_valid[i] set, searching ptr, ptr+1, …, wrapping mod NREQ.
  - `req_ready[g]` = advance for the granted requester g only; all other bits are 0.
  - `req_ready` is all zero while `rst` is low.
- On a transfer:
  - tag[0] <= {1, g}; `tanh_a` = req_data[g].
  - ptr <= (g+1) mod NREQ.
- Advance with no valid request:
  - A bubble is inserted: tag[0].valid <= 0 and `tanh_a` = 0.
  - `ptr` is unchanged.
- While advance is low:
  - `tanh_a` holds its last value and `tanh_en` is 0.
  - `ptr` and the tags are unchanged.
- Output: `y_valid` = tag[LAT-1].valid; `y_id` = tag[LAT-1].id; `y` = `tanh_y` (combinational passthrough).
- `busy` = OR of all tag valid bits.
- Requesters must hold `req_data` stable while valid and not ready.
- Operand values are never inspected or modified; saturation and the sign rule belong to `tanh`.
- Reset mid-operation:
  - All tags are cleared and in-flight results are discarded (no `y_valid`).
  - `ptr` returns to 0.
  - The `tanh` unit's own registers are reset by the parent on the same reset.

## Timing
- Reset values: `req_ready`=0, `tanh_en`=1 (pipeline empty), `tanh_a`=0, `y_valid`=0, `y_id`=0, `busy`=0.
- Latency: an operand accepted at edge N appears with `y_valid` high after edge N+LAT-1 (LAT enabled cycles), assuming no stall.
- Throughput: one result per cycle with continuous requests and `y_ready` held high.
- Stall: `y_valid` with `y_ready` low holds `y`, `y_id` and all stages; no new grant is issued.
- Stall release: `y_ready` and a new request in the same cycle result in the output retiring and a new operand being accepted in that cycle.
- Fairness: with all NREQ requesters continuously valid, each is granted exactly once in every NREQ consecutive grants.

## Configuration
- `TANH_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority, lowest index wins; `ptr` is not implemented.
  - Undefined (default): round-robin as described above.

## Test plan
- Reset, then requester 0 sends 0x04800000 (4.5) with `y_ready` held 1 -> after LAT cycles `y_valid`=1, `y`=0x01000000, `y_id`=0; `busy` falls the following cycle.
- All 4 requesters continuously valid with ids as data -> grant order 0,1,2,3,0,…; one `y_valid` per cycle; `y_id` sequence matches the grant sequence.
- Requester 2 sends 0xFB800000 (-4.5) while `y_ready` is held 0 for 5 cycles -> `y`=0xFF000000 and `y_id`=2 stay stable; `tanh_en`=0; `req_ready`=0 throughout; the result retires one cycle after `y_ready` rises.
- Requests on 1 and 3 only, starting with ptr=2 -> 3 is granted first, then 1.
- `rst` asserted with 2 operands in flight -> `y_valid` and `busy` drop immediately; no stale result appears after reset is released.
- Same stimulus with `TANH_ARB_FIXED_PRIO_EN` defined and requesters 0 and 1 continuously valid -> requester 0 is always granted.
